// File: rtl/key_buzz_player_pkg.sv
// Shared constants for the key-code buzzer player: FSM encoding, key codes,
// default pitch and duration terminal counts for a 50 MHz clock.
package key_buzz_player_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  localparam logic [2:0] KEY_NONE = 3'd0;
  localparam logic [2:0] KEY_1    = 3'd1;
  localparam logic [2:0] KEY_2    = 3'd2;
  localparam logic [2:0] KEY_3    = 3'd3;
  localparam logic [2:0] KEY_4    = 3'd4;

  localparam logic [16:0] DEF_HALF_P1  = 17'd95_419;
  localparam logic [16:0] DEF_HALF_P2  = 17'd75_756;
  localparam logic [16:0] DEF_HALF_P3  = 17'd63_774;
  localparam logic [16:0] DEF_HALF_P4  = 17'd47_800;
  localparam logic [23:0] DEF_BEEP_MAX = 24'd9_999_999;

  // Only codes 1..4 are key events; 0 is "no event", 5..7 are garbage.
  function automatic logic is_valid_key(input logic [2:0] code);
    return (code >= KEY_1) && (code <= KEY_4);
  endfunction

endpackage

// File: rtl/key_buzz_player_if.sv
// Debounced key-code input plus buzzer status outputs, as seen by the player.
interface key_buzz_player_if;
  logic [2:0] key_val;
  logic       buzz;
  logic       busy;
  logic [2:0] tone_id;

  modport master (output key_val, input buzz, busy, tone_id);
  modport slave  (input key_val, output buzz, busy, tone_id);
endinterface

// File: rtl/key_buzz_player_tone_gen.sv
// Square-wave generator: half-period counter plus toggle flop, restartable
// to a high level and forced low whenever it is not enabled.
module buzz_tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        enable,
  input  logic [16:0] half_max,
  output logic        wave
);

  logic [16:0] half_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_cnt <= '0;
      wave     <= 1'b0;
    end else if (restart) begin
      half_cnt <= '0;
      wave     <= 1'b1;
    end else if (enable) begin
      if (half_cnt == half_max) begin
        half_cnt <= '0;
        wave     <= ~wave;
      end else begin
        half_cnt <= half_cnt + 17'd1;
      end
    end else begin
      half_cnt <= '0;
      wave     <= 1'b0;
    end
  end

endmodule

// File: rtl/key_buzz_player.sv
// Plays a fixed-length tone on the buzzer for each debounced key code 1..4;
// a new valid code retriggers immediately, even on the expiry cycle.
module key_buzz_player
  import key_buzz_player_pkg::*;
#(
  parameter logic [16:0] HALF_P1  = DEF_HALF_P1,
  parameter logic [16:0] HALF_P2  = DEF_HALF_P2,
  parameter logic [16:0] HALF_P3  = DEF_HALF_P3,
  parameter logic [16:0] HALF_P4  = DEF_HALF_P4,
  parameter logic [23:0] BEEP_MAX = DEF_BEEP_MAX
) (
  input  logic              clk,
  input  logic              rst,
  key_buzz_player_if.slave  bus
);

  logic [0:0]  state;
  logic [2:0]  tone_id;
  logic [23:0] dur_cnt;
  logic [16:0] half_max;
  logic        key_ok;
  logic        expire;
  logic        tone_en;
  logic        wave;

  assign key_ok  = is_valid_key(bus.key_val);
  assign expire  = (state == ST_PLAY) && (dur_cnt == BEEP_MAX);
  // Expiry forces the wave low, even if a half-period toggle was also due.
  assign tone_en = (state == ST_PLAY) && !expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      tone_id <= KEY_NONE;
      dur_cnt <= '0;
    end else if (key_ok) begin
      state   <= ST_PLAY;
      tone_id <= bus.key_val;
      dur_cnt <= '0;
    end else if (state == ST_PLAY) begin
      if (expire) begin
        state   <= ST_IDLE;
        tone_id <= KEY_NONE;
        dur_cnt <= '0;
      end else begin
        dur_cnt <= dur_cnt + 24'd1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    half_max = HALF_P1;
    case (tone_id)
      KEY_2:   half_max = HALF_P2;
      KEY_3:   half_max = HALF_P3;
      KEY_4:   half_max = HALF_P4;
      default: half_max = HALF_P1;
    endcase
  end

  buzz_tone_gen u_tone_gen (
    .clk      (clk),
    .rst      (rst),
    .restart  (key_ok),
    .enable   (tone_en),
    .half_max (half_max),
    .wave     (wave)
  );

  assign bus.buzz    = wave;
  assign bus.busy    = state;
  assign bus.tone_id = tone_id;

endmodule

// File: tb/tb_key_buzz_player.sv
// Directed self-checking bench for key_buzz_player with short pitch and
// duration terminal counts (half periods 3..6, tone length 100 cycles).
module tb_key_buzz_player;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  key_buzz_player_if bus ();

  key_buzz_player #(
    .HALF_P1  (17'd3),
    .HALF_P2  (17'd4),
    .HALF_P3  (17'd5),
    .HALF_P4  (17'd6),
    .BEEP_MAX (24'd99)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},    bus.busy,    0);
    check({tag, ".buzz"},    bus.buzz,    0);
    check({tag, ".tone_id"}, bus.tone_id, 0);
  endtask

  // Present 'code' for one cycle, then check ncyc cycles starting at the
  // start edge (k=0). Expected buzz is high for k in [0,H], low for [H+1,2H+1], ...
  // With noise set, invalid codes 0/5/6/7 are driven during the tone.
  task automatic run_tone(input string tag, input logic [2:0] code, input int half,
                          input int ncyc, input bit noise);
    logic [2:0] junk [4];
    junk[0] = 3'd5; junk[1] = 3'd0; junk[2] = 3'd6; junk[3] = 3'd7;
    bus.key_val = code;
    tick();
    for (int k = 0; k < ncyc; k++) begin
      bus.key_val = noise ? junk[k % 4] : 3'd0;
      check($sformatf("%s.k%0d.busy", tag, k),    bus.busy,    1);
      check($sformatf("%s.k%0d.tone_id", tag, k), bus.tone_id, {29'd0, code});
      check($sformatf("%s.k%0d.buzz", tag, k),    bus.buzz,
            ((k / (half + 1)) % 2 == 0) ? 1 : 0);
      tick();
    end
    bus.key_val = 3'd0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    bus.key_val = 3'd0;
    rst         = 1'b0;

    // Power-on reset
    repeat (3) tick();
    check_idle("por");
    #2 rst = 1'b1;
    tick();
    repeat (3) tick();
    check_idle("post_por");

    // Invalid codes in IDLE leave it idle
    for (int v = 5; v <= 8; v++) begin
      bus.key_val = 3'(v);
      tick();
      check_idle($sformatf("idle_inv%0d", v % 8));
    end
    bus.key_val = 3'd0;
    tick();

    // Single tone: code 1, half period 4 cycles, idle at start+100
    run_tone("tone1", 3'd1, 3, 100, 1'b0);
    check_idle("tone1_end");
    tick();
    check_idle("tone1_end2");

    // Pitch select
    run_tone("tone2", 3'd2, 4, 100, 1'b0);
    check_idle("tone2_end");
    run_tone("tone3", 3'd3, 5, 100, 1'b0);
    check_idle("tone3_end");
    run_tone("tone4", 3'd4, 6, 100, 1'b0);
    check_idle("tone4_end");

    // Retrigger mid-tone: code 4 lands at start+50, tone ends 100 later
    run_tone("retrig_a", 3'd1, 3, 49, 1'b0);
    run_tone("retrig_b", 3'd4, 6, 100, 1'b0);
    check_idle("retrig_end");

    // Retrigger on the expiry cycle: no idle gap
    run_tone("exp_a", 3'd3, 5, 99, 1'b0);
    run_tone("exp_b", 3'd2, 4, 100, 1'b0);
    check_idle("exp_end");

    // Invalid codes during PLAY must not disturb the tone
    run_tone("noise", 3'd3, 5, 100, 1'b1);
    check_idle("noise_end");

    // Asynchronous reset mid-tone
    run_tone("pre_rst", 3'd4, 6, 10, 1'b0);
    #3 rst = 1'b0;
    #1;
    check_idle("rst_async");
    repeat (3) tick();
    check_idle("rst_hold");
    #2 rst = 1'b1;
    repeat (4) tick();
    check_idle("rst_release");
    run_tone("post_rst", 3'd2, 4, 100, 1'b0);
    check_idle("post_rst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_buzz_player.md
Name: key_buzz_player

Overview:
- Consumer end of the debounced key-code interface: takes the single-cycle key codes (1..4) from the key scanner and plays a fixed-length square-wave tone on the buzzer pin.
- Each code selects one of four pitches.
- A new valid code retriggers immediately.
- Sits between the key debouncer and the board buzzer pin; one 50 MHz clock domain.

Parameters:
- HALF_P1, 17'd95_419, terminal count of the half-period counter for code 1 (~262 Hz at 50 MHz)
- HALF_P2, 17'd75_756, terminal count for code 2 (~330 Hz)
- HALF_P3, 17'd63_774, terminal count for code 3 (~392 Hz)
- HALF_P4, 17'd47_800, terminal count for code 4 (~523 Hz)
- BEEP_MAX, 24'd9_999_999, terminal count of the tone-duration counter (200 ms)

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-low reset
- key_val  input  3  key code from the debouncer; 0 = no event; 1..4 = single-cycle key event; 5..7 = invalid
- buzz  output  1  buzzer drive, square wave while playing, 0 when silent
- busy  output  1  high while a tone is playing
- tone_id  output  3  code of the tone currently playing, 0 when idle

Behaviour:
- Reset (async, rst=0): state IDLE; buzz=0; busy=0; tone_id=0; half counter=0; duration counter=0.
- States: IDLE, PLAY.
- Valid code: key_val in 1..4, sampled on every clk edge.
- Latency: a valid code in cycle N gives, at edge N+1: state=PLAY, busy=1, tone_id=key_val, buzz=1, half counter=0, duration counter=0.
- Tone generation in PLAY:
  - The half counter increments each cycle.
  - When it equals HALF_P[tone_id], buzz toggles and the counter clears.
  - Each buzz level therefore lasts HALF_P+1 cycles.
- Duration in PLAY:
  - The duration counter increments each cycle.
  - When it equals BEEP_MAX and no valid code is present: next edge state=IDLE, buzz=0, busy=0, tone_id=0, both counters clear.
  - Tone length is BEEP_MAX+1 cycles from the start edge.
- Retrigger: a valid code in PLAY (same or different code) restarts exactly as from IDLE.
  - The new tone_id is loaded, buzz=1 and both counters clear.
  - Retrigger takes priority over duration expiry in the same cycle.
- Codes 0 and 5..7 are ignored in every state and have no effect on counters or outputs.
- Simultaneous half-period toggle and duration expiry: expiry wins and buzz=0.
- Reset mid-tone: all outputs return to their reset values immediately (asynchronous).
- Widths: half counter is 17 bit, duration counter is 24 bit. Neither counter can exceed its terminal value, so there is no wrap-around.
- Every output is registered; there are no combinational paths from key_val to any output.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, PLAY=1'b1
  - key-code constants: KEY_NONE=0, KEY_1..KEY_4 = 1..4
  - default HALF_Pn and BEEP_MAX values
- One sub-module, buzz_tone_gen:
  - inputs: clk, rst, restart, enable, half_max[16:0]
  - output: registered square wave
  - function: 17-bit half-period counter plus toggle flop
- The top level holds the FSM, the duration counter and the tone_id-to-HALF_P mux.

Test Plan (simulation overrides: HALF_P1..4 = 3,4,5,6; BEEP_MAX = 99):
- Reset: assert rst=0 mid-sim with a tone active -> buzz=0, busy=0, tone_id=0 in the same cycle, held until release; after release, idle until a code arrives.
- Single tone: key_val=1 for one cycle at N -> at N+1 busy=1, tone_id=1, buzz=1.
  - buzz toggles every 4 cycles.
  - busy falls and buzz=0 at edge N+101.
- Pitch select: codes 2, 3, 4 -> buzz half-periods of 5, 6, 7 cycles respectively; tone_id=2, 3, 4.
- Retrigger: key_val=1 at N, key_val=4 at N+50 -> at N+51 tone_id=4, buzz=1, half-period becomes 7 cycles; busy falls at edge N+151.
- Retrigger at expiry: key_val=2 in the cycle the duration counter equals 99 -> no idle gap; busy stays 1 and tone_id=2.
- Invalid codes: key_val=0, 5, 6, 7 in IDLE and in PLAY -> no state, counter or output change versus a reference run without them.
